// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg
//   Shared definitions for the sequential restoring divider.
//   - N_DEF   : default divisor/remainder width (dividend/quotient are 2*N_DEF)
//   - state_t : controller states IDLE (ready for operands), CALC (iterating),
//               DONE (result presented, waiting for the consumer)
package seq_divider_pkg;

  localparam int N_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_divider_div_step.sv
// div_step
//   One combinational restoring-division iteration.  The partial remainder is
//   shifted left with the next dividend bit appended, giving an N+1 bit trial
//   value.  If the trial is >= divisor it is reduced by the divisor and the
//   quotient bit is 1; otherwise it passes through and the quotient bit is 0.
// Ports
//   rem_in   in  N    partial remainder from the previous iteration (< divisor)
//   bit_in   in  1    next dividend bit, MSB first
//   divisor  in  N    denominator (non-zero whenever this result is used)
//   rem_out  out N    updated partial remainder (< divisor)
//   q_bit    out 1    quotient bit produced by this iteration
module div_step
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);

  logic [N:0]   trial;
  logic [N-1:0] diff;

  always_comb begin
    trial   = {rem_in, bit_in};
    q_bit   = (trial >= {1'b0, divisor});
    // When the subtraction is taken the true difference is below the divisor,
    // so the low N bits of the modular difference are exact.
    diff    = trial[N-1:0] - divisor;
    rem_out = q_bit ? diff : trial[N-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider
//   Multi-cycle unsigned restoring divider.  Takes a 2N-bit dividend and an
//   N-bit divisor over valid/ready and returns a 2N-bit quotient and N-bit
//   remainder over valid/ready, one quotient bit per clock, MSB first.
//   Handshake: a transfer happens on a rising edge where valid and ready are
//   both high; a producer holds valid and data until that edge, a consumer
//   may drop ready at any time and the producer keeps its outputs stable.
//   Latency: out_valid rises 2N edges after the accepting edge; a zero
//   divisor skips the iterations and its result is registered by the
//   accepting edge itself.
// Ports
//   clk, rst_n          clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   operand handshake; in_ready is high only in IDLE
//   dividend [2N]       numerator
//   divisor  [N]        denominator
//   out_valid/out_ready result handshake
//   quotient [2N]       dividend / divisor (all ones when divisor == 0)
//   remainder [N]       dividend % divisor (dividend[N-1:0] when divisor == 0)
//   div_by_zero         result came from a zero divisor
//   chk_err             only with SEQ_DIVIDER_SELFCHECK_EN defined: set on
//                       entry to DONE when quotient*divisor+remainder differs
//                       from the dividend; cleared when the result is drained
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int N = N_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_by_zero
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  ,
  output logic           chk_err
`endif
);

  localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * N - 1);

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [2*N-1:0] shift_q;   // dividend bits still to consume, MSB first
  logic [N-1:0]   div_q;     // latched divisor
  logic [N-1:0]   rem_q;     // partial remainder
  logic [2*N-2:0] quo_q;     // quotient bits gathered so far

  logic [N-1:0]   step_rem;
  logic           step_q;
  logic [2*N-1:0] next_quo;

  div_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .bit_in  (shift_q[2*N-1]),
    .divisor (div_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  assign next_quo = {quo_q, step_q};
  assign in_ready = (state == IDLE);

`ifdef SEQ_DIVIDER_SELFCHECK_EN
  localparam int PW = 3 * N;
  logic [2*N-1:0] orig_q;    // untouched copy of the dividend for the check
  logic [PW-1:0]  recon;
  logic           chk_next;

  assign recon    = PW'(next_quo) * PW'(div_q) + PW'(step_rem);
  assign chk_next = (recon != PW'(orig_q));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      shift_q     <= '0;
      div_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
      orig_q      <= '0;
      chk_err     <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            shift_q <= dividend;
            div_q   <= divisor;
            rem_q   <= '0;
            quo_q   <= '0;
            cnt     <= '0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
            orig_q  <= dividend;
            chk_err <= 1'b0;
`endif
            if (divisor == '0) begin
              state       <= DONE;
              out_valid   <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[N-1:0];
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
            end
          end
        end
        CALC: begin
          rem_q   <= step_rem;
          quo_q   <= next_quo[2*N-2:0];
          shift_q <= {shift_q[2*N-2:0], 1'b0};
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            state       <= DONE;
            out_valid   <= 1'b1;
            quotient    <= next_quo;
            remainder   <= step_rem;
            div_by_zero <= 1'b0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
            chk_err     <= chk_next;
`endif
          end
        end
        DONE: begin
          // Outputs other than out_valid keep their value after the drain.
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
            chk_err   <= 1'b0;
`endif
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider
//   Self-checking bench for seq_divider (N = 4).  Directed vectors from a
//   table, hand-written sequences for back-pressure and reset abort, and
//   random operands checked against an arithmetic reference model.
//   With SEQ_DIVIDER_SELFCHECK_EN defined it also sweeps every operand pair
//   and checks that chk_err stays low.
module tb_seq_divider;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [2*N-1:0] dividend = '0;
  logic [N-1:0]   divisor = '0;
  logic           out_valid;
  logic           out_ready = 1'b0;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_by_zero;
`ifdef SEQ_DIVIDER_SELFCHECK_EN
  logic           chk_err;
`endif

  seq_divider #(.N(N)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
`ifdef SEQ_DIVIDER_SELFCHECK_EN
    ,
    .chk_err     (chk_err)
`endif
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [12:0] exp_q[$];   // {quotient[7:0], remainder[3:0], div_by_zero}

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // Reference model: plain unsigned division with the divide-by-zero rule.
  function automatic logic [12:0] model(input logic [7:0] a, input logic [3:0] b);
    int q;
    int r;
    if (b == 4'd0) return {8'hFF, a[3:0], 1'b1};
    q = int'(a) / int'(b);
    r = int'(a) % int'(b);
    return {q[7:0], r[3:0], 1'b0};
  endfunction

  // Edges between the accepting edge and the edge that raises out_valid.
  // A zero divisor is registered by the accepting edge itself (0); a normal
  // division takes 2N iterations (8).
  function automatic int model_lat(input logic [3:0] b);
    return (b == 4'd0) ? 0 : 2 * N;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic start_op(input logic [7:0] a, input logic [3:0] b);
    @(negedge clk);
    check("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
  endtask

  // Returns at a negedge with out_valid high (or after the bound expired);
  // scribbles on the operand inputs meanwhile, which must be ignored.
  task automatic wait_result(output int lat);
    lat = 0;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      in_valid = 1'($urandom_range(0, 1));
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      @(negedge clk);
      lat++;
    end
    if (!out_valid) check("result_timeout", out_valid, 1);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_scored(input string tag, input logic [7:0] a, input logic [3:0] b, input int hold);
    logic [12:0] e;
    int lat;
    exp_q.push_back(model(a, b));
    start_op(a, b);
    wait_result(lat);
    repeat (hold) @(negedge clk);
    e = exp_q.pop_front();
    check({tag, "_quotient"}, quotient, e[12:5]);
    check({tag, "_remainder"}, remainder, e[4:1]);
    check({tag, "_div_by_zero"}, div_by_zero, e[0]);
    check({tag, "_latency"}, lat, model_lat(b));
    drain();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0] a;
    logic [3:0] b;
    logic [7:0] q;
    logic [3:0] r;
    logic       z;
    int         lat;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int lat;
    bit seen;

    vecs[0] = '{8'd25,  4'd5,  8'd5,   4'd0,  1'b0, 8};
    vecs[1] = '{8'd200, 4'd15, 8'd13,  4'd5,  1'b0, 8};
    vecs[2] = '{8'd255, 4'd1,  8'd255, 4'd0,  1'b0, 8};
    vecs[3] = '{8'd7,   4'd9,  8'd0,   4'd7,  1'b0, 8};
    vecs[4] = '{8'd37,  4'd0,  8'd255, 4'd5,  1'b1, 0};
    vecs[5] = '{8'd0,   4'd3,  8'd0,   4'd0,  1'b0, 8};
    vecs[6] = '{8'd255, 4'd15, 8'd17,  4'd0,  1'b0, 8};
    vecs[7] = '{8'd254, 4'd15, 8'd16,  4'd14, 1'b0, 8};
    vecs[8] = '{8'd0,   4'd0,  8'd255, 4'd0,  1'b1, 0};

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_by_zero", div_by_zero, 0);
    rst_n = 1'b1;

    // ---- table ----
    for (int i = 0; i < 9; i++) begin
      start_op(vecs[i].a, vecs[i].b);
      wait_result(lat);
      check($sformatf("vec%0d_quotient", i), quotient, vecs[i].q);
      check($sformatf("vec%0d_remainder", i), remainder, vecs[i].r);
      check($sformatf("vec%0d_div_by_zero", i), div_by_zero, vecs[i].z);
      check($sformatf("vec%0d_latency", i), lat, vecs[i].lat);
      drain();
    end

    // ---- back-pressure: hold 5 cycles, then drain with in_valid high ----
    start_op(8'd100, 4'd7);
    wait_result(lat);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      dividend = 8'($urandom);
      divisor  = 4'd0;
      @(negedge clk);
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, 14);
      check("hold_remainder", remainder, 2);
    end
    out_ready = 1'b1;          // in_valid stays high across the drain edge
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("drain_in_ready", in_ready, 1);
    check("drain_no_same_edge_accept", out_valid, 0);

    // ---- reset three edges into CALC ----
    start_op(8'd25, 4'd5);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_quotient", quotient, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_result", seen, 0);
    run_scored("after_abort", 8'd25, 4'd5, 0);

    // ---- random operands against the model ----
    for (int i = 0; i < 40; i++) begin
      logic [3:0] b;
      b = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      run_scored("rand", 8'($urandom_range(0, 255)), b, $urandom_range(0, 3));
    end

`ifdef SEQ_DIVIDER_SELFCHECK_EN
    // ---- exhaustive sweep: internal consistency flag must stay low ----
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        start_op(8'(a), 4'(b));
        wait_result(lat);
        check($sformatf("chk_err_%0d_%0d", a, b), chk_err, 0);
        drain();
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
